user_wrapper_rr_mux_wr: RTL and testbench
=========================================

USER_WRAPPER_RR_MUX_WR -- requirements
Module: user_wrapper_rr_mux_wr

Interface
REQ-001 SHALL have parameter N_SRCS, default 4: number of source streams, legal range 1..16.
REQ-002 SHALL have parameter DATA_BITS, default AXI_DATA_BITS: tdata width; tkeep width is DATA_BITS/8.
REQ-003 SHALL have parameter ID_BITS, default PID_BITS: tid width.
REQ-004 SHALL have derived localparam SEL_BITS = max(1, clog2(N_SRCS)).
REQ-005 aclk  input  1  sole clock; all state on rising edge.
REQ-006 areset  input  1  reset, asynchronous, active-high.
REQ-007 s_axis  AXI4SR slave array [N_SRCS]  source streams: tvalid, tready, tdata, tkeep, tlast, tid.
REQ-008 m_axis  AXI4SR master  merged output stream, same fields.
REQ-009 port_out  output  SEL_BITS  registered index of the currently granted source.
REQ-010 port_busy  output  1  high while a packet is locked to port_out.

Function
REQ-011 SHALL arbitrate per packet, round-robin, and SHALL never interleave beats of different packets on m_axis.
REQ-012 SHALL implement two states: IDLE and LOCKED.
REQ-013 IDLE: all s_axis tready = 0; if any source tvalid = 1, SHALL select the first valid index at or after rr_ptr (ascending, modulo N_SRCS), register it into grant/port_out, and enter LOCKED next cycle.
REQ-014 IDLE with no valid source: SHALL remain IDLE; grant, port_out and rr_ptr hold.
REQ-015 LOCKED: s_axis[grant].tready = (out_cnt < 2); tready of every other source = 0.
REQ-016 LOCKED: a handshake on s_axis[grant] with tlast = 1 SHALL set rr_ptr = (grant + 1) mod N_SRCS and return to IDLE next cycle.
REQ-017 Requests from non-granted sources SHALL have no effect until the locked packet's tlast beat is accepted.
REQ-018 port_busy SHALL be 1 exactly in LOCKED.
REQ-019 Output stage SHALL be a 2-entry FIFO (out_cnt 0..2) holding tdata, tkeep, tlast, tid; m_axis.tvalid = (out_cnt != 0); m_axis fields come from the FIFO head.
REQ-020 Latency: a beat accepted on s_axis in cycle t SHALL appear on m_axis from cycle t+1.
REQ-021 Throughput: with m_axis.tready held 1, SHALL transfer one beat per cycle within a packet; exactly one idle input cycle (IDLE arbitration) between packets.
REQ-022 Simultaneous push and pop at out_cnt = 1 SHALL leave out_cnt = 1; push is blocked at out_cnt = 2 even if pop occurs that cycle.
REQ-023 Beat contents (tdata, tkeep, tlast, tid) SHALL pass unmodified and in order; no beat dropped or duplicated.
REQ-024 m_axis outputs SHALL stay stable while tvalid = 1 and tready = 0.
REQ-025 N_SRCS = 1: rr_ptr and port_out SHALL stay 0; packet-locking and IDLE bubble still apply.
REQ-026 rr_ptr wrap: grant = N_SRCS-1 with tlast SHALL set rr_ptr = 0.

Reset
REQ-027 areset = 1 SHALL immediately (asynchronously) force: state IDLE, grant = 0, port_out = 0, port_busy = 0, rr_ptr = 0, out_cnt = 0, m_axis.tvalid = 0, all s_axis tready = 0.
REQ-028 Reset mid-packet SHALL discard FIFO contents and the partial packet; no tlast is synthesised.
REQ-029 First rising aclk edge after areset deassertion SHALL behave as an IDLE cycle.

Verification (N_SRCS = 4)
REQ-030 Src2 alone sends 3-beat packet twice, m_tready = 1 -> port_out = 2, port_busy high per packet, beats out contiguous, one idle cycle between packets, tids/data match.
REQ-031 All sources continuously valid with 1-beat packets -> output tid order 0,1,2,3,0,1...; rr_ptr wraps 3 -> 0.
REQ-032 Src1 4-beat packet, m_tready = 0 for 5 cycles after beat 1 -> out_cnt reaches 2, s_axis[1].tready = 0, all 4 beats delivered in order after release.
REQ-033 Src1 packet in progress, src0 raises tvalid at beat 2 -> src0 tready stays 0 until src1 tlast accepted; then src2/src3 idle, so src0 granted next.
REQ-034 rr_ptr = 2, only src1 and src3 valid -> src3 packet first, then src1.
REQ-035 areset pulsed during beat 2 of a src0 packet -> m_tvalid = 0, port_busy = 0 immediately; after release src0 re-granted first, no stale beats emitted.

Source files
------------

// File: rtl/user_wrapper_rr_mux_wr_if.sv
// Stream bundle for the round-robin mux. N_LANES parallel AXI4-Stream lanes.
// Use N_LANES = N_SRCS for the source side and N_LANES = 1 for the merged output.
interface user_wrapper_rr_mux_wr_if #(
   parameter int unsigned N_LANES   = 1,
   parameter int unsigned DATA_BITS = 64,
   parameter int unsigned ID_BITS   = 4
);
   logic [N_LANES-1:0]                  tvalid;
   logic [N_LANES-1:0]                  tready;
   logic [N_LANES-1:0][DATA_BITS-1:0]   tdata;
   logic [N_LANES-1:0][DATA_BITS/8-1:0] tkeep;
   logic [N_LANES-1:0]                  tlast;
   logic [N_LANES-1:0][ID_BITS-1:0]     tid;

   modport master (output tvalid, tdata, tkeep, tlast, tid, input tready);
   modport slave  (input tvalid, tdata, tkeep, tlast, tid, output tready);
endinterface

// File: rtl/user_wrapper_rr_mux_wr.sv
// Packet-level round-robin merge of N_SRCS AXI4-Stream sources.
// The merged output passes through a 2-entry FIFO.
module user_wrapper_rr_mux_wr #(
   parameter int unsigned N_SRCS    = 4,
   parameter int unsigned DATA_BITS = 64,
   parameter int unsigned ID_BITS   = 4,
   localparam int unsigned SEL_BITS = (N_SRCS > 1) ? $clog2(N_SRCS) : 1
) (
   input  logic                      aclk,
   input  logic                      areset,
   user_wrapper_rr_mux_wr_if.slave   s_axis,
   user_wrapper_rr_mux_wr_if.master  m_axis,
   output logic [SEL_BITS-1:0]       port_out,
   output logic                      port_busy
);
   localparam int unsigned KEEP_BITS = DATA_BITS / 8;

   typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

   typedef struct packed {
      logic [DATA_BITS-1:0] data;
      logic [KEEP_BITS-1:0] keep;
      logic                 last;
      logic [ID_BITS-1:0]   id;
   } beat_t;

   state_t              r_state, w_state_nxt;
   logic [SEL_BITS-1:0] r_grant, w_grant_nxt;
   logic [SEL_BITS-1:0] r_rr_ptr, w_rr_nxt;
   logic [SEL_BITS-1:0] w_pick;
   logic                w_any;
   logic [1:0]          r_cnt;
   beat_t               r_slot [2];
   beat_t               w_in;
   logic                w_sel_valid;
   logic [N_SRCS-1:0]   w_tready;
   logic                w_push, w_pop;

   // First valid source at or after r_rr_ptr, wrapping modulo N_SRCS.
   always_comb begin
      int unsigned idx;
      idx    = 0;
      w_any  = 1'b0;
      w_pick = '0;
      for (int unsigned i = 0; i < N_SRCS; i++) begin
         idx = (32'(r_rr_ptr) + i) % N_SRCS;
         if (!w_any && s_axis.tvalid[idx]) begin
            w_any  = 1'b1;
            w_pick = SEL_BITS'(idx);
         end
      end
   end

   assign w_sel_valid = s_axis.tvalid[r_grant];
   assign w_in.data   = s_axis.tdata[r_grant];
   assign w_in.keep   = s_axis.tkeep[r_grant];
   assign w_in.last   = s_axis.tlast[r_grant];
   assign w_in.id     = s_axis.tid[r_grant];

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_rr_nxt    = r_rr_ptr;
      w_tready    = '0;
      w_push      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_grant_nxt = w_pick;
               w_state_nxt = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            w_tready[r_grant] = (r_cnt != 2'd2);
            w_push            = w_sel_valid && (r_cnt != 2'd2);
            if (w_push && w_in.last) begin
               w_state_nxt = ST_IDLE;
               w_rr_nxt    = (r_grant == SEL_BITS'(N_SRCS - 1)) ? '0 : r_grant + 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_pop = (r_cnt != 2'd0) && m_axis.tready[0];

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state  <= ST_IDLE;
         r_grant  <= '0;
         r_rr_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_grant  <= w_grant_nxt;
         r_rr_ptr <= w_rr_nxt;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Slot 0 is always the head; a pop shifts slot 1 forward, push-with-pop refills the head.
   always_ff @(posedge aclk) begin
      case ({w_push, w_pop})
         2'b10: begin
            if (r_cnt == 2'd0) r_slot[0] <= w_in;
            else               r_slot[1] <= w_in;
         end
         2'b01:   r_slot[0] <= r_slot[1];
         2'b11:   r_slot[0] <= w_in;
         default: ;
      endcase
   end

   assign s_axis.tready   = w_tready;
   assign m_axis.tvalid[0] = (r_cnt != 2'd0);
   assign m_axis.tdata[0]  = r_slot[0].data;
   assign m_axis.tkeep[0]  = r_slot[0].keep;
   assign m_axis.tlast[0]  = r_slot[0].last;
   assign m_axis.tid[0]    = r_slot[0].id;
   assign port_out         = r_grant;
   assign port_busy        = (r_state == ST_LOCKED);
endmodule

// File: tb/tb_user_wrapper_rr_mux_wr.sv
// Directed bench for user_wrapper_rr_mux_wr (N_SRCS = 4): queued packet sources,
// an output beat recorder, and hand-computed expectations per scenario.
module tb_user_wrapper_rr_mux_wr;
   localparam int unsigned NS = 4;
   localparam int unsigned DW = 64;
   localparam int unsigned IW = 4;

   typedef struct {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      logic [3:0]  id;
      int          cyc;
   } beat_t;

   logic       aclk;
   logic       areset;
   logic [1:0] port_out;
   logic       port_busy;

   user_wrapper_rr_mux_wr_if #(.N_LANES(NS), .DATA_BITS(DW), .ID_BITS(IW)) s_if ();
   user_wrapper_rr_mux_wr_if #(.N_LANES(1),  .DATA_BITS(DW), .ID_BITS(IW)) m_if ();

   user_wrapper_rr_mux_wr #(.N_SRCS(NS), .DATA_BITS(DW), .ID_BITS(IW)) dut (
      .aclk      (aclk),
      .areset    (areset),
      .s_axis    (s_if),
      .m_axis    (m_if),
      .port_out  (port_out),
      .port_busy (port_busy)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int    n_checks = 0;
   int    n_fail   = 0;
   int    cyc      = 0;
   logic  mrdy     = 1'b1;
   logic  hs [NS];
   beat_t srcq [NS][$];
   beat_t obs [$];

   function automatic logic [63:0] enc(int s, int p, int b);
      return {8'hD0, 8'(s), 8'(p), 8'(b), 32'h1234_5678 ^ 32'(s * 7 + b)};
   endfunction

   function automatic logic [7:0] kp(int b, logic last);
      return last ? 8'h3F : (8'hFF ^ 8'(b << 6));
   endfunction

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      n_checks++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic add_pkt(input int s, input int p, input int n);
      beat_t b;
      for (int i = 0; i < n; i++) begin
         b.d   = enc(s, p, i);
         b.l   = (i == n - 1);
         b.k   = kp(i, b.l);
         b.id  = 4'(s);
         b.cyc = 0;
         srcq[s].push_back(b);
      end
   endtask

   task automatic drive_sources();
      for (int i = 0; i < NS; i++) begin
         if (srcq[i].size() > 0) begin
            s_if.tvalid[i] = 1'b1;
            s_if.tdata[i]  = srcq[i][0].d;
            s_if.tkeep[i]  = srcq[i][0].k;
            s_if.tlast[i]  = srcq[i][0].l;
            s_if.tid[i]    = srcq[i][0].id;
         end else begin
            s_if.tvalid[i] = 1'b0;
            s_if.tdata[i]  = '0;
            s_if.tkeep[i]  = '0;
            s_if.tlast[i]  = 1'b0;
            s_if.tid[i]    = '0;
         end
      end
   endtask

   // One clock: update drivers just after the edge, record handshakes at the falling edge.
   task automatic cycle();
      beat_t b;
      @(posedge aclk);
      #1;
      for (int i = 0; i < NS; i++) begin
         if (hs[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
         hs[i] = 1'b0;
      end
      drive_sources();
      m_if.tready[0] = mrdy;
      cyc++;
      @(negedge aclk);
      for (int i = 0; i < NS; i++) hs[i] = s_if.tvalid[i] && s_if.tready[i];
      if (m_if.tvalid[0] && m_if.tready[0]) begin
         b.d = m_if.tdata[0]; b.k = m_if.tkeep[0]; b.l = m_if.tlast[0];
         b.id = m_if.tid[0]; b.cyc = cyc;
         obs.push_back(b);
      end
   endtask

   task automatic flush();
      for (int i = 0; i < NS; i++) begin
         srcq[i].delete();
         hs[i] = 1'b0;
      end
      obs.delete();
      drive_sources();
   endtask

   task automatic do_reset();
      areset = 1'b1;
      flush();
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      areset = 1'b0;
   endtask

   task automatic chk_beat(input string tag, input int s, input int p, input int b, input int n,
                           output int stamp);
      beat_t o;
      logic  lst;
      stamp = -1;
      chk({tag, "_present"}, 64'(obs.size() > 0), 64'd1);
      if (obs.size() > 0) begin
         o   = obs.pop_front();
         lst = (b == n - 1);
         chk({tag, "_data"}, o.d, enc(s, p, b));
         chk({tag, "_keep"}, 64'(o.k), 64'(kp(b, lst)));
         chk({tag, "_last"}, 64'(o.l), 64'(lst));
         chk({tag, "_tid"},  64'(o.id), 64'(s));
         stamp = o.cyc;
      end
   endtask

   initial begin
      int st [6];
      int dummy;
      int exp_busy [10];
      int exp_off [6];
      int ord_s [8];

      areset = 1'b1;
      m_if.tready[0] = 1'b1;
      flush();

      // Reset state
      @(posedge aclk);
      @(negedge aclk);
      chk("rst_busy",   64'(port_busy), 64'd0);
      chk("rst_port",   64'(port_out), 64'd0);
      chk("rst_mvalid", 64'(m_if.tvalid[0]), 64'd0);
      chk("rst_sready", 64'(s_if.tready), 64'd0);

      // A: src2 alone, two 3-beat packets
      do_reset();
      mrdy = 1'b1;
      add_pkt(2, 0, 3);
      add_pkt(2, 1, 3);
      exp_busy = '{0, 1, 1, 1, 0, 1, 1, 1, 0, 0};
      for (int c = 0; c < 10; c++) begin
         cycle();
         chk($sformatf("A_busy_c%0d", c + 1), 64'(port_busy), 64'(exp_busy[c]));
         chk($sformatf("A_port_c%0d", c + 1), 64'(port_out), (c == 0) ? 64'd0 : 64'd2);
      end
      for (int i = 0; i < 6; i++)
         chk_beat($sformatf("A_beat%0d", i), 2, i / 3, i % 3, 3, st[i]);
      exp_off = '{0, 1, 2, 4, 5, 6};
      for (int i = 1; i < 6; i++)
         chk($sformatf("A_gap%0d", i), 64'(st[i] - st[0]), 64'(exp_off[i]));
      chk("A_extra", 64'(obs.size()), 64'd0);

      // B: all sources valid with 1-beat packets, order 0,1,2,3,0,1,2,3
      do_reset();
      for (int p = 0; p < 2; p++)
         for (int s = 0; s < NS; s++) add_pkt(s, p, 1);
      repeat (18) cycle();
      ord_s = '{0, 1, 2, 3, 0, 1, 2, 3};
      for (int i = 0; i < 8; i++)
         chk_beat($sformatf("B_pkt%0d", i), ord_s[i], i / 4, 0, 1, dummy);
      chk("B_extra", 64'(obs.size()), 64'd0);

      // C: src1 4-beat packet with output stalled five cycles
      do_reset();
      add_pkt(1, 0, 4);
      repeat (3) cycle();
      mrdy = 1'b0;
      cycle();
      chk("C_ready_c4", 64'(s_if.tready[1]), 64'd1);
      for (int c = 5; c <= 8; c++) begin
         cycle();
         chk($sformatf("C_ready_c%0d", c), 64'(s_if.tready[1]), 64'd0);
         chk($sformatf("C_mvalid_c%0d", c), 64'(m_if.tvalid[0]), 64'd1);
         chk($sformatf("C_hold_c%0d", c), m_if.tdata[0], enc(1, 0, 1));
      end
      mrdy = 1'b1;
      cycle();
      chk("C_ready_c9", 64'(s_if.tready[1]), 64'd0);
      chk("C_hold_c9", m_if.tdata[0], enc(1, 0, 1));
      repeat (4) cycle();
      for (int i = 0; i < 4; i++) chk_beat($sformatf("C_beat%0d", i), 1, 0, i, 4, dummy);
      chk("C_extra", 64'(obs.size()), 64'd0);

      // D: src0 requests mid-packet of src1
      do_reset();
      add_pkt(1, 0, 4);
      repeat (3) cycle();
      add_pkt(0, 0, 2);
      cycle();
      chk("D_r0_c4", 64'(s_if.tready[0]), 64'd0);
      chk("D_port_c4", 64'(port_out), 64'd1);
      cycle();
      chk("D_r0_c5", 64'(s_if.tready[0]), 64'd0);
      chk("D_r1_c5", 64'(s_if.tready[1]), 64'd1);
      cycle();
      chk("D_busy_c6", 64'(port_busy), 64'd0);
      chk("D_r0_c6", 64'(s_if.tready[0]), 64'd0);
      cycle();
      chk("D_port_c7", 64'(port_out), 64'd0);
      chk("D_busy_c7", 64'(port_busy), 64'd1);
      chk("D_r0_c7", 64'(s_if.tready[0]), 64'd1);
      repeat (4) cycle();
      for (int i = 0; i < 4; i++) chk_beat($sformatf("D_s1b%0d", i), 1, 0, i, 4, dummy);
      for (int i = 0; i < 2; i++) chk_beat($sformatf("D_s0b%0d", i), 0, 0, i, 2, dummy);
      chk("D_extra", 64'(obs.size()), 64'd0);

      // E: rr_ptr = 2 with src1 and src3 pending
      do_reset();
      add_pkt(1, 0, 1);
      repeat (2) cycle();
      add_pkt(1, 1, 2);
      add_pkt(3, 0, 2);
      cycle();
      chk("E_busy_c3", 64'(port_busy), 64'd0);
      cycle();
      chk("E_port_c4", 64'(port_out), 64'd3);
      repeat (3) cycle();
      chk("E_port_c7", 64'(port_out), 64'd1);
      repeat (4) cycle();
      chk_beat("E_a",  1, 0, 0, 1, dummy);
      chk_beat("E_c0", 3, 0, 0, 2, dummy);
      chk_beat("E_c1", 3, 0, 1, 2, dummy);
      chk_beat("E_b0", 1, 1, 0, 2, dummy);
      chk_beat("E_b1", 1, 1, 1, 2, dummy);
      chk("E_extra", 64'(obs.size()), 64'd0);

      // F: reset asserted mid-packet of src0
      do_reset();
      add_pkt(0, 0, 4);
      repeat (4) cycle();
      chk("F_busy_pre", 64'(port_busy), 64'd1);
      flush();
      areset = 1'b1;
      #1;
      chk("F_mvalid_rst", 64'(m_if.tvalid[0]), 64'd0);
      chk("F_busy_rst",   64'(port_busy), 64'd0);
      chk("F_sready_rst", 64'(s_if.tready), 64'd0);
      chk("F_port_rst",   64'(port_out), 64'd0);
      #1;
      areset = 1'b0;
      add_pkt(0, 7, 2);
      cycle();
      chk("F_busy_c1", 64'(port_busy), 64'd0);
      cycle();
      chk("F_busy_c2", 64'(port_busy), 64'd1);
      chk("F_port_c2", 64'(port_out), 64'd0);
      repeat (4) cycle();
      chk_beat("F_b0", 0, 7, 0, 2, dummy);
      chk_beat("F_b1", 0, 7, 1, 2, dummy);
      chk("F_extra", 64'(obs.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
